fpu_div16: RTL and testbench

Sequential half-precision (fp16) floating-point division coprocessor. It is the inverse-operation companion to the fp16 multiplier and uses the same operand/result types, the same start/done handshake and the same `{Z, C, N, V}` condition-code bundle. The FPU top level can therefore issue either operation through an identical protocol. Significands are divided by a radix-2 restoring divider, one quotient bit per cycle, followed by one normalize/round cycle.

---
 rtl/fpu_div16.sv | 219 +++++++++++++++++++++
 tb/tb_fpu_div16.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fpu_div16.sv
// fpu_div16: sequential fp16 divider with a start/done handshake and {Z, C, N, V} flags.
// The significand quotient comes from a radix-2 restoring divider that produces one
// bit per cycle (13 bits). One normalize/round cycle follows, and then the result is published.
// Optional feature macro FPU_DIV_EARLY_SPECIAL_EN sends special-case operands
// straight from the latch to the round state, which shortens their latency.
module fpu_div16 (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] fpuIn1,
    input  logic [15:0] fpuIn2,
    output logic [15:0] fpuOut,
    output logic        done,
    output logic [3:0]  condCodes
);

    typedef enum logic [1:0] {
        DIV_WAIT  = 2'd0,
        DIV_ITER  = 2'd1,
        DIV_ROUND = 2'd2,
        DIV_DONE  = 2'd3
    } div_state_t;

    div_state_t        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              sign_q, sign_d;
    logic signed [6:0] exp_q, exp_d;
    logic [10:0]       dsr_q, dsr_d;
    logic [11:0]       rem_q, rem_d;
    logic [12:0]       quo_q, quo_d;
    logic              spec_q, spec_d;
    logic [15:0]       spec_out_q, spec_out_d;
    logic [3:0]        spec_cc_q, spec_cc_d;
    logic [15:0]       out_q, out_d;
    logic [3:0]        cc_q, cc_d;
    logic              done_q, done_d;

    logic [4:0]        e1, e2;
    logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic              lat_sign, lat_spec;
    logic [15:0]       lat_out;
    logic [3:0]        lat_cc;
    logic signed [6:0] lat_exp;
    logic              accept;

    assign e1       = fpuIn1[14:10];
    assign e2       = fpuIn2[14:10];
    assign a_zero   = (e1 == 5'd0);
    assign b_zero   = (e2 == 5'd0);
    assign a_inf    = (e1 == 5'h1F) && (fpuIn1[9:0] == 10'd0);
    assign b_inf    = (e2 == 5'h1F) && (fpuIn2[9:0] == 10'd0);
    assign a_nan    = (e1 == 5'h1F) && (fpuIn1[9:0] != 10'd0);
    assign b_nan    = (e2 == 5'h1F) && (fpuIn2[9:0] != 10'd0);
    assign lat_sign = fpuIn1[15] ^ fpuIn2[15];
    assign lat_exp  = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 7'sd15;
    assign accept   = start && ((state_q == DIV_WAIT) || (state_q == DIV_DONE));

    // Resolve special operands at latch time (subnormals already count as zero).
    always_comb begin
        lat_spec = 1'b1;
        lat_out  = 16'h0000;
        lat_cc   = 4'b0000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            lat_out = 16'h7E00;
        end else if (a_inf) begin
            lat_out = {lat_sign, 15'h7C00};
            lat_cc  = {2'b00, lat_sign, 1'b0};
        end else if (b_zero) begin
            lat_out = {lat_sign, 15'h7C00};
            lat_cc  = {1'b0, 1'b1, lat_sign, 1'b0};
        end else if (b_inf || a_zero) begin
            lat_out = {lat_sign, 15'h0000};
            lat_cc  = {1'b1, 1'b0, lat_sign, 1'b0};
        end else begin
            lat_spec = 1'b0;
        end
    end

    logic [11:0] rem_sub, rem_step;
    logic        q_bit;

    // One restoring step: subtract the divisor when it fits, then double the remainder.
    always_comb begin
        q_bit    = (rem_q >= {1'b0, dsr_q});
        rem_sub  = q_bit ? (rem_q - {1'b0, dsr_q}) : rem_q;
        rem_step = rem_sub << 1;
    end

    logic [9:0]        frac_raw;
    logic              guard, sticky, round_inc;
    logic [10:0]       frac_sum;
    logic signed [6:0] exp_n, exp_r;
    logic [15:0]       round_out;
    logic [3:0]        round_cc;

    // Normalize the quotient, round to nearest even and clamp to inf or zero.
    always_comb begin
        if (quo_q[12]) begin
            frac_raw = quo_q[11:2];
            guard    = quo_q[1];
            sticky   = quo_q[0] | (rem_q != 12'd0);
            exp_n    = exp_q;
        end else begin
            frac_raw = quo_q[10:1];
            guard    = quo_q[0];
            sticky   = (rem_q != 12'd0);
            exp_n    = exp_q - 7'sd1;
        end
        round_inc = guard & (sticky | frac_raw[0]);
        frac_sum  = {1'b0, frac_raw} + {10'd0, round_inc};
        exp_r     = frac_sum[10] ? (exp_n + 7'sd1) : exp_n;
        if (spec_q) begin
            round_out = spec_out_q;
            round_cc  = spec_cc_q;
        end else if (exp_r >= 7'sd31) begin
            round_out = {sign_q, 15'h7C00};
            round_cc  = {2'b00, sign_q, 1'b1};
        end else if (exp_r <= 7'sd0) begin
            round_out = {sign_q, 15'h0000};
            round_cc  = {1'b1, 1'b0, sign_q, 1'b0};
        end else begin
            round_out = {sign_q, exp_r[4:0], frac_sum[9:0]};
            round_cc  = {2'b00, sign_q, 1'b0};
        end
    end

    // Next-state and datapath control for the wait/iterate/round/done sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        dsr_d      = dsr_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        spec_d     = spec_q;
        spec_out_d = spec_out_q;
        spec_cc_d  = spec_cc_q;
        out_d      = out_q;
        cc_d       = cc_q;
        done_d     = done_q;
        case (state_q)
            DIV_ITER: begin
                rem_d = rem_step;
                quo_d = {quo_q[11:0], q_bit};
                if (cnt_q == 4'd0) begin
                    state_d = DIV_ROUND;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DIV_ROUND: begin
                out_d   = round_out;
                cc_d    = round_cc;
                state_d = DIV_DONE;
            end
            DIV_DONE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
        if (accept) begin
            sign_d     = lat_sign;
            exp_d      = lat_exp;
            dsr_d      = {1'b1, fpuIn2[9:0]};
            rem_d      = {2'b01, fpuIn1[9:0]};
            quo_d      = 13'd0;
            cnt_d      = 4'd12;
            spec_d     = lat_spec;
            spec_out_d = lat_out;
            spec_cc_d  = lat_cc;
            done_d     = 1'b0;
`ifdef FPU_DIV_EARLY_SPECIAL_EN
            state_d    = lat_spec ? DIV_ROUND : DIV_ITER;
`else
            state_d    = DIV_ITER;
`endif
        end
    end

    // State and result registers; reset clears everything, including a division in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= DIV_WAIT;
            cnt_q      <= 4'd0;
            sign_q     <= 1'b0;
            exp_q      <= 7'sd0;
            dsr_q      <= 11'd0;
            rem_q      <= 12'd0;
            quo_q      <= 13'd0;
            spec_q     <= 1'b0;
            spec_out_q <= 16'h0000;
            spec_cc_q  <= 4'b0000;
            out_q      <= 16'h0000;
            cc_q       <= 4'b0000;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            dsr_q      <= dsr_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            spec_q     <= spec_d;
            spec_out_q <= spec_out_d;
            spec_cc_q  <= spec_cc_d;
            out_q      <= out_d;
            cc_q       <= cc_d;
            done_q     <= done_d;
        end
    end

    assign fpuOut    = out_q;
    assign condCodes = cc_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fpu_div16.sv
// tb_fpu_div16: directed-vector bench for fpu_div16 with an arithmetic reference model.
module tb_fpu_div16;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] fpuIn1;
    logic [15:0] fpuIn2;
    logic [15:0] fpuOut;
    logic        done;
    logic [3:0]  condCodes;

    int          compared   = 0;
    int          mismatched = 0;
    logic [15:0] expOut     = 16'h0000;
    logic [3:0]  expCc      = 4'b0000;

    localparam int NVEC = 12;
    localparam logic [15:0] VEC_A   [NVEC] = '{16'h3C00, 16'h3C00, 16'hC400, 16'h4500, 16'h0000, 16'h7C00,
                                               16'h0000, 16'h4000, 16'h7BFF, 16'h0400, 16'h4500, 16'h4000};
    localparam logic [15:0] VEC_B   [NVEC] = '{16'h4000, 16'h4200, 16'h4000, 16'h0000, 16'h0000, 16'h7C00,
                                               16'h4000, 16'h7C00, 16'h0400, 16'h7BFF, 16'h4200, 16'h4200};
    localparam logic [15:0] VEC_OUT [NVEC] = '{16'h3800, 16'h3555, 16'hC000, 16'h7C00, 16'h7E00, 16'h7E00,
                                               16'h0000, 16'h0000, 16'h7C00, 16'h0000, 16'h3EAB, 16'h3955};
    localparam logic [3:0]  VEC_CC  [NVEC] = '{4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b0000,
                                               4'b1000, 4'b1000, 4'b0001, 4'b1000, 4'b0000, 4'b0000};

    fpu_div16 dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .fpuIn1    (fpuIn1),
        .fpuIn2    (fpuIn2),
        .fpuOut    (fpuOut),
        .done      (done),
        .condCodes (condCodes)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference quotient: the exact integer quotient and remainder, then the fp16 rounding rules.
    function automatic logic [19:0] divModel(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, fa, fb, ma, mb, num, q, r, frac, g, st, e;
        logic s;
        logic aZero, bZero, aInf, bInf, aNan, bNan;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        fa = int'(a[9:0]);
        fb = int'(b[9:0]);
        s  = a[15] ^ b[15];
        aZero = (ea == 0);
        bZero = (eb == 0);
        aInf  = (ea == 31) && (fa == 0);
        bInf  = (eb == 31) && (fb == 0);
        aNan  = (ea == 31) && (fa != 0);
        bNan  = (eb == 31) && (fb != 0);
        if (aNan || bNan || (aZero && bZero) || (aInf && bInf)) return {16'h7E00, 4'b0000};
        if (aInf)                                               return {s, 15'h7C00, 2'b00, s, 1'b0};
        if (bZero)                                              return {s, 15'h7C00, 1'b0, 1'b1, s, 1'b0};
        if (bInf || aZero)                                      return {s, 15'h0000, 1'b1, 1'b0, s, 1'b0};
        ma  = 1024 + fa;
        mb  = 1024 + fb;
        num = ma * 4096;
        q   = num / mb;
        r   = num % mb;
        if (q >= 4096) begin
            frac = (q >> 2) & 1023;
            g    = (q >> 1) & 1;
            st   = ((q & 1) != 0 || r != 0) ? 1 : 0;
            e    = ea - eb + 15;
        end else begin
            frac = (q >> 1) & 1023;
            g    = q & 1;
            st   = (r != 0) ? 1 : 0;
            e    = ea - eb + 14;
        end
        if (g == 1 && (st == 1 || (frac & 1) == 1)) frac = frac + 1;
        if (frac == 1024) begin
            frac = 0;
            e    = e + 1;
        end
        if (e >= 31) return {s, 15'h7C00, 2'b00, s, 1'b1};
        if (e <= 0)  return {s, 15'h0000, 1'b1, 1'b0, s, 1'b0};
        return {s, e[4:0], frac[9:0], 2'b00, s, 1'b0};
    endfunction

    function automatic bit isSpecial(input logic [15:0] a, input logic [15:0] b);
        return (a[14:10] == 5'd0) || (a[14:10] == 5'h1F) || (b[14:10] == 5'd0) || (b[14:10] == 5'h1F);
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compared = compared + 1;
        if (actual !== expected) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, actual, expected, $time);
        end
    endtask

    // Launch one division, then count edges until done rises and compare against the expected latency.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input bit pulseMid);
        int lat;
        int expLat;
        logic [19:0] m;
        @(negedge clock);
        fpuIn1 = a;
        fpuIn2 = b;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start  = 1'b0;
        m      = divModel(a, b);
        expOut = m[19:4];
        expCc  = m[3:0];
        checkOutput("done low after accept", {15'd0, done}, 16'd0);
        expLat = 15;
`ifdef FPU_DIV_EARLY_SPECIAL_EN
        if (isSpecial(a, b)) expLat = 2;
`endif
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (pulseMid && k == 4) begin
                fpuIn1 = 16'h4500;
                fpuIn2 = 16'h3C00;
                start  = 1'b1;
            end
            @(posedge clock);
            #1;
            start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        checkOutput("done latency", 16'(lat), 16'(expLat));
    endtask

    // Whenever done is high, the published result must match the model for the last accepted operands.
    always @(negedge clock) begin
        if (done) begin
            checkOutput("fpuOut", fpuOut, expOut);
            checkOutput("condCodes", {12'd0, condCodes}, {12'd0, expCc});
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [19:0] m;
        reset  = 1'b0;
        start  = 1'b0;
        fpuIn1 = 16'h0000;
        fpuIn2 = 16'h0000;

        for (int i = 0; i < NVEC; i++) begin
            m = divModel(VEC_A[i], VEC_B[i]);
            checkOutput("model result", m[19:4], VEC_OUT[i]);
            checkOutput("model flags", {12'd0, m[3:0]}, {12'd0, VEC_CC[i]});
        end

        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset done", {15'd0, done}, 16'd0);
        checkOutput("reset fpuOut", fpuOut, 16'h0000);
        checkOutput("reset condCodes", {12'd0, condCodes}, 16'd0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(VEC_A[i], VEC_B[i], (i == NVEC - 1));
        end

        applyStimulus(16'h7BFF, 16'h0400, 1'b0);
        @(negedge clock);
        fpuIn1 = 16'h3C00;
        fpuIn2 = 16'h4200;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("mid-op reset done", {15'd0, done}, 16'd0);
        checkOutput("mid-op reset fpuOut", fpuOut, 16'h0000);
        checkOutput("mid-op reset condCodes", {12'd0, condCodes}, 16'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("idle after reset done", {15'd0, done}, 16'd0);

        applyStimulus(16'h4200, 16'h3C00, 1'b0);
        repeat (3) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
